// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add or restoring divide
// on one shared XLEN+1-bit adder, followed by a sign-correction (FIX) cycle.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [2:0]      state_o
);

  // Handshake: start is honoured only in IDLE with kill low; busy covers MUL/DIV/FIX;
  // done is a single-cycle pulse in DONE with result already stable that cycle.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          funct3_q;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     opa_q, opb_q, result_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                neg_q, neg_rem_q;

  logic                a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]     mag_a, mag_b, fast_res, fix_res;
  logic                div_by_zero, div_ovf, fast, accept;
  logic [XLEN:0]       add_x, add_y, add_sum;
  logic                add_cin;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    sa    = a_signed & op_a[XLEN-1];
    sb    = b_signed & op_b[XLEN-1];
    mag_a = sa ? -op_a : op_a;
    mag_b = sb ? -op_b : op_b;
  end

  always_comb begin
    div_by_zero = funct3[2] && (op_b == '0);
    div_ovf     = funct3[2] && !funct3[0] && (op_a == SMIN) && (op_b == '1);
    fast        = div_by_zero || div_ovf;
    accept      = (state_q == S_IDLE) && start && !kill;
    if (div_by_zero) fast_res = funct3[1] ? op_a : '1;
    else             fast_res = funct3[1] ? '0 : SMIN;
  end

  // Shared adder: add multiplicand to the upper accumulator half in MUL,
  // subtract the divisor from the shifted remainder in DIV.
  always_comb begin
    if (state_q == S_DIV) begin
      add_x   = acc_q[2*XLEN-1:XLEN-1];
      add_y   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_y   = opb_q[0] ? {1'b0, opa_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = add_x + add_y + {{XLEN{1'b0}}, add_cin};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = fast ? S_DONE : (funct3[2] ? S_DIV : S_MUL);
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_DIV:  if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_comb begin
    busy    = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    done    = (state_q == S_DONE);
    result  = result_q;
    state_o = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q  <= '0;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      funct3_q  <= funct3;
      cnt_q     <= '0;
      opa_q     <= mag_a;
      opb_q     <= mag_b;
      neg_q     <= sa ^ sb;
      neg_rem_q <= sa;
      acc_q     <= funct3[2] ? {{XLEN{1'b0}}, mag_a} : '0;
      if (fast) result_q <= fast_res;
    end else if (!kill) begin
      case (state_q)
        S_MUL: begin
          acc_q <= {add_sum, acc_q[XLEN-1:1]};
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q + CW'(1);
        end
        S_DIV: begin
          // add_sum[XLEN] set means the trial subtraction went negative: restore.
          if (!add_sum[XLEN]) acc_q <= {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                acc_q <= {acc_q[2*XLEN-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX:   result_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed vectors, latency/busy checks,
// kill, ignored start, and asynchronous reset mid-operation.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .kill    (kill),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one operation from IDLE and scoreboards result, latency and busy length.
  // poke_at > 0 raises start for one cycle while the operation is running.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int poke_at);
    int cycles;
    int busy_cnt;
    logic got;
    logic [31:0] exp_v;
    @(negedge clk);
    check({tag, "_gap_done"}, 32'(done), 32'd0);
    check({tag, "_gap_busy"}, 32'(busy), 32'd0);
    exp_q.push_back(exp);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    cycles = 0; busy_cnt = 0; got = 1'b0;
    while (!got && cycles < 100) begin
      @(negedge clk);
      start = (poke_at > 0 && cycles == poke_at);
      if (start) begin
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
      end
      cycles++;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    exp_v = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, "_result"}, result, exp_v);
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0; kill = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;

    run_op("mul_neg",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    run_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    run_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    run_op("mulhsu",     3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 0);
    run_op("mul_small",  3'b000, 32'd6,        32'd7,        32'd42,       34, 0);
    run_op("divu",       3'b101, 32'd100,      32'd7,        32'd14,       34, 0);
    run_op("remu",       3'b111, 32'd100,      32'd7,        32'd2,        34, 0);
    run_op("div_neg",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
    run_op("rem_neg",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
    run_op("rem_negb",   3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34, 0);
    run_op("div_negb",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 0);
    run_op("remu_big",   3'b111, 32'hFFFFFFFF, 32'h10,       32'hF,        34, 0);

    run_op("div_by0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("rem_by0",    3'b110, 32'd5,        32'd0,        32'd5,        1, 0);
    run_op("divu_by0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    run_op("divu_poke",  3'b101, 32'd100,      32'd7,        32'd14,       34, 5);

    // kill ten cycles into a DIV: nothing completes and result keeps 14
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
    end
    check("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    check("kill_result", result, 32'd14);
    check("kill_no_done", 32'(done_cnt), 32'd0);
    run_op("after_kill", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34, 0);

    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; funct3 = 3'b011; op_a = 32'd9; op_b = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("arst_no_done", 32'(done_cnt), 32'd0);
    run_op("after_rst", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in the execute stage and accepts an operation when the decoder flags an M-extension instruction (opcode 0110011, funct7 0000001). It runs a 32-step shift-add or restoring-divide loop on one shared adder/subtractor, then applies sign correction. It holds the core via `busy` until it returns the result with a one-cycle `done` pulse.

## Interface
- `XLEN`, 32: operand/result width; the iteration count equals `XLEN`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` in XLEN: rs1 value (multiplicand/dividend).
- `op_b` in XLEN: rs2 value (multiplier/divisor).
- `kill` in 1: synchronous abort (pipeline flush).
- `busy` out 1: high in MUL, DIV and FIX; the pipeline stalls on it.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out XLEN: registered result; holds its value until the next `done`.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, `start=1`, `kill=0`:
  - Latch `funct3`.
  - Latch magnitudes |op_a| and |op_b|. An operand is treated as signed for MULH and DIV/REM, `op_a` only for MULHSU, and neither for MULHU/DIVU/REMU. MUL uses magnitudes too; its low word is sign-invariant.
  - Latch sign flags: product/quotient negative = sa^sb; remainder negative = sa.
  - Clear the 5-bit counter, then go to MUL or DIV.
- Fast path from IDLE, taken when `start=1` and `kill=0`; skips the loop, loads `result`, next state DONE:
  - Divide by zero (`op_b=0`): DIV/DIVU → 0xFFFFFFFF; REM/REMU → `op_a`.
  - Signed overflow (DIV/REM with `op_a=0x80000000`, `op_b=0xFFFFFFFF`): DIV → 0x80000000; REM → 0.
- MUL:
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2·XLEN accumulator (XLEN+1-bit add, carry kept).
  - Then shift the accumulator right by 1 and shift the multiplier right by 1.
  - After count 31, go to FIX.
- DIV (restoring):
  - Each cycle: shift {rem, quo} left by 1 and trial-subtract the divisor from rem (XLEN+1 bits).
  - If the result is non-negative, keep it and set quo[0]=1; otherwise restore.
  - After count 31, go to FIX.
- FIX: negate the 2·XLEN product, quotient or remainder per the sign flags. Select the output:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Write `result`, then go to DONE.
- DONE: `done=1` for one cycle, then go to IDLE. `start` in DONE is ignored; the core may re-issue in the following IDLE cycle.
- `kill`:
  - In any state, the next state is IDLE with no `done` and `result` unchanged.
  - `kill` together with `start` in IDLE means the request is dropped.
  - `kill` in DONE: `done` is still high that cycle (already committed); the next state is IDLE.
- `start` while not in IDLE is ignored.
- Reset mid-operation: immediate return to reset values. There is no completion and no `done`.

## Timing
- Reset values:
  - state IDLE, `busy=0`, `done=0`, `result=0`.
  - counter 0; accumulator and operand registers 0.
- Normal latency:
  - `start` is sampled at edge E0.
  - Iterations run at E1..E32; FIX runs at E33 (`result` written).
  - `done=1` in the cycle after E33.
  - `busy` is high from after E0 until E33.
  - Throughput is one operation per 35 cycles (the DONE cycle and one IDLE cycle are included).
- Fast-path latency: `start` at E0, `result` written at E0, `done=1` in the cycle after E0, `busy` never asserted.
- `done` never lasts more than one cycle and is never asserted without a preceding accepted `start`.
- Outputs are all registered; no combinational path from inputs to outputs.

## Test plan
- MUL `op_a`=7, `op_b`=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` in the 34th cycle after the `start` edge, `busy` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU → 2. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- Divide by zero (DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5) and overflow (DIV 0x80000000/−1 → 0x80000000, REM → 0) → `done` in the cycle after `start`, `busy` stays 0.
- `kill` 10 cycles into a DIV → IDLE next cycle, no `done`, `result` keeps its old value; a back-to-back `start` then completes correctly. A `start` during `busy` is ignored.
- `rst_n` pulsed low asynchronously mid-MUL → `busy`, `done` and `result` drop to 0 immediately; no `done` after release.
